adder_result_stage: RTL and testbench

ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

---
 rtl/adder_result_stage.sv | 123 ++++++++++++
 tb/tb_adder_result_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_stage.sv
// Result stage behind a 32-bit adder. It derives the {N,Z,C,V} flags for each
// result, buffers up to two results in order with a valid/ready handshake on
// both sides, and keeps a saturating count of overflowing results that have
// been delivered downstream.
module adder_result_stage #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_sum,
  input  logic                 in_cout,
  input  logic                 in_a_msb,
  input  logic                 in_b_msb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_sum,
  output logic [3:0]           out_flags,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  localparam logic [OVF_CNT_W-1:0] OVF_MAX = {OVF_CNT_W{1'b1}};
  localparam logic [OVF_CNT_W-1:0] OVF_ONE = OVF_CNT_W'(1);

  // Flags in {N,Z,C,V} order. Signed overflow happens when both operands
  // share a sign and the sum's sign differs from it.
  function automatic logic [3:0] calc_flags(
    input logic [31:0] sum,
    input logic        cout,
    input logic        a_msb,
    input logic        b_msb
  );
    logic n, z, c, v;
    n = sum[31];
    z = (sum == 32'h0000_0000);
    c = cout;
    v = (a_msb == b_msb) & (sum[31] != a_msb);
    return {n, z, c, v};
  endfunction

  // The head entry always sits in head_*_r, so the outputs come straight
  // from registers; the tail slot only holds the second-oldest result.
  logic [1:0]           count_r;
  logic [31:0]          head_sum_r;
  logic [3:0]           head_flags_r;
  logic [31:0]          tail_sum_r;
  logic [3:0]           tail_flags_r;
  logic [OVF_CNT_W-1:0] ovf_cnt_r;

  logic                 push_s;
  logic                 pop_s;
  logic [3:0]           new_flags_s;

  assign in_ready    = (count_r < 2'd2);
  assign out_valid   = (count_r != 2'd0);
  assign push_s      = in_valid & in_ready;
  assign pop_s       = out_valid & out_ready;
  assign new_flags_s = calc_flags(in_sum, in_cout, in_a_msb, in_b_msb);

  assign out_sum   = head_sum_r;
  assign out_flags = head_flags_r;
  assign ovf_cnt   = ovf_cnt_r;

  // Two-entry in-order buffer: occupancy count plus head/tail slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= 2'd0;
      head_sum_r   <= 32'h0000_0000;
      head_flags_r <= 4'b0000;
      tail_sum_r   <= 32'h0000_0000;
      tail_flags_r <= 4'b0000;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_sum_r   <= in_sum;
            head_flags_r <= new_flags_s;
            count_r      <= 2'd1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            // Head leaves and the new result replaces it directly.
            head_sum_r   <= in_sum;
            head_flags_r <= new_flags_s;
          end else if (push_s) begin
            tail_sum_r   <= in_sum;
            tail_flags_r <= new_flags_s;
            count_r      <= 2'd2;
          end else if (pop_s) begin
            count_r      <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen.
          if (pop_s) begin
            head_sum_r   <= tail_sum_r;
            head_flags_r <= tail_flags_r;
            count_r      <= 2'd1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to empty.
          count_r <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of delivered overflow results; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= '0;
    end else if (ovf_clr) begin
      ovf_cnt_r <= '0;
    end else if (pop_s && head_flags_r[0] && (ovf_cnt_r != OVF_MAX)) begin
      ovf_cnt_r <= ovf_cnt_r + OVF_ONE;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Randomised and directed bench for adder_result_stage. Two instances share
// the same stimulus: the default-width one and one with a 2-bit overflow
// counter so that saturation is reachable quickly.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_sum;
  logic        in_cout;
  logic        in_a_msb;
  logic        in_b_msb;
  logic        out_ready;
  logic        ovf_clr;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_sum,   out_sum2;
  logic [3:0]  out_flags, out_flags2;
  logic [7:0]  ovf_cnt;
  logic [1:0]  ovf_cnt2;

  adder_result_stage #(.OVF_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_flags(out_flags), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  adder_result_stage #(.OVF_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_flags(out_flags2), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of pending results and two overflow tallies.
  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_ovf8;
  int unsigned m_ovf2;
  logic [31:0] dut_pop[$];

  function automatic ent_t model_entry(input logic [31:0] s, input logic c,
                                       input logic am, input logic bm);
    ent_t e;
    bit neg_res, same_sign, ovf;
    neg_res   = (s >= 32'h8000_0000);
    same_sign = (am == bm);
    ovf       = same_sign && (neg_res != am);
    e.sum   = s;
    e.flags = {neg_res, (s == 32'd0), c, ovf};
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},  64'(out_valid),  64'(mq.size() != 0));
    check({tag, ".ready"},  64'(in_ready),   64'(mq.size() < 2));
    check({tag, ".valid2"}, 64'(out_valid2), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({tag, ".sum"},   64'(out_sum),   64'(mq[0].sum));
      check({tag, ".flags"}, 64'(out_flags), 64'(mq[0].flags));
      check({tag, ".sum2"},  64'(out_sum2),  64'(mq[0].sum));
    end
    check({tag, ".ovf8"}, 64'(ovf_cnt),  64'(m_ovf8));
    check({tag, ".ovf2"}, 64'(ovf_cnt2), 64'(m_ovf2));
  endtask

  // One clock cycle: check state, drive inputs, advance the model.
  task automatic step(input logic iv, input logic [31:0] s, input logic c,
                      input logic am, input logic bm, input logic ordy,
                      input logic clr, output logic accepted);
    ent_t head;
    bit   do_pop, do_push;
    check_outputs("cyc");
    in_valid  = iv;
    in_sum    = s;
    in_cout   = c;
    in_a_msb  = am;
    in_b_msb  = bm;
    out_ready = ordy;
    ovf_clr   = clr;
    do_pop  = (mq.size() > 0) && ordy;
    do_push = iv && (mq.size() < 2);
    if (out_valid && ordy) dut_pop.push_back(out_sum);
    head.sum   = 32'd0;
    head.flags = 4'd0;
    if (do_pop) head = mq.pop_front();
    if (clr) begin
      m_ovf8 = 0;
      m_ovf2 = 0;
    end else if (do_pop && head.flags[0]) begin
      if (m_ovf8 < 255) m_ovf8++;
      if (m_ovf2 < 3)   m_ovf2++;
    end
    if (do_push) mq.push_back(model_entry(s, c, am, bm));
    accepted = do_push;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic send(input logic [31:0] s, input logic am, input logic bm,
                      input logic ordy, output logic acc);
    step(1'b1, s, 1'b0, am, bm, ordy, 1'b0, acc);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b0));
    check({tag, ".ready"}, 64'(in_ready),  64'(1'b1));
    check({tag, ".sum"},   64'(out_sum),   64'(32'd0));
    check({tag, ".flags"}, 64'(out_flags), 64'(4'd0));
    check({tag, ".ovf8"},  64'(ovf_cnt),   64'(8'd0));
    check({tag, ".ovf2"},  64'(ovf_cnt2),  64'(2'd0));
    mq.delete();
    m_ovf8 = 0;
    m_ovf2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] sent[$];
    logic [31:0] s;
    int          k;

    rst_n = 1'b0;
    in_valid = 1'b0; in_sum = 32'd0; in_cout = 1'b0;
    in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf8 = 0; m_ovf2 = 0;
    #1;
    check("por.valid", 64'(out_valid), 64'(1'b0));
    check("por.ovf8",  64'(ovf_cnt),   64'(8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Zero result with carry: Z and C set, one cycle latency, then empty.
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("r031.valid", 64'(out_valid), 64'(1'b1));
    check("r031.sum",   64'(out_sum),   64'(32'd0));
    check("r031.flags", 64'(out_flags), 64'(4'b0110));
    idle(1'b1);
    check("r031.empty", 64'(out_valid), 64'(1'b0));

    // Positive + positive giving a negative sum: N and V set.
    send(32'h8000_0000, 1'b0, 1'b0, 1'b1, acc);
    check("r032.flags", 64'(out_flags), 64'(4'b1001));
    idle(1'b1);
    check("r032.ovf", 64'(ovf_cnt), 64'(8'd1));

    // Backpressure: third value waits until a slot frees up.
    dut_pop.delete();
    send(32'h11, 1'b0, 1'b0, 1'b0, acc);
    send(32'h22, 1'b0, 1'b0, 1'b0, acc);
    send(32'h33, 1'b0, 1'b0, 1'b0, acc);
    check("r033.third_held", 64'(acc), 64'(1'b0));
    check("r033.ready_low", 64'(in_ready), 64'(1'b0));
    send(32'h33, 1'b0, 1'b0, 1'b0, acc);
    acc = 1'b0;
    k = 0;
    while (!acc && k < 8) begin
      send(32'h33, 1'b0, 1'b0, 1'b1, acc);
      k++;
    end
    check("r033.accept_bound", 64'(acc), 64'(1'b1));
    idle(1'b1);
    idle(1'b1);
    check("r033.n_out", 64'(dut_pop.size()), 64'(3));
    if (dut_pop.size() == 3) begin
      check("r033.out0", 64'(dut_pop[0]), 64'(32'h11));
      check("r033.out1", 64'(dut_pop[1]), 64'(32'h22));
      check("r033.out2", 64'(dut_pop[2]), 64'(32'h33));
    end

    // Streaming: one result per cycle with the buffer holding one entry.
    dut_pop.delete();
    sent.delete();
    for (int i = 0; i < 100; i++) begin
      s = $urandom;
      sent.push_back(s);
      send(s, s[3], s[7], 1'b1, acc);
      check("r034.ready", 64'(in_ready),  64'(1'b1));
      check("r034.valid", 64'(out_valid), 64'(1'b1));
    end
    idle(1'b1);
    check("r034.n_out", 64'(dut_pop.size()), 64'(100));
    if (dut_pop.size() == 100) begin
      for (int i = 0; i < 100; i++) check("r034.order", 64'(dut_pop[i]), 64'(sent[i]));
    end

    // Saturation of the 2-bit counter, then clear racing an overflow pop.
    apply_reset("rst1");
    for (int i = 0; i < 5; i++) send(32'h8000_0000, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b1);
    check("r035.sat2", 64'(ovf_cnt2), 64'(2'd3));
    check("r035.cnt8", 64'(ovf_cnt),  64'(8'd5));
    send(32'h8000_0000, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check("r035.clr2", 64'(ovf_cnt2), 64'(2'd0));
    check("r035.clr8", 64'(ovf_cnt),  64'(8'd0));

    // Reset while full with a non-zero counter, then a fresh push.
    send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, acc);
    send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, acc);
    idle(1'b1);
    check("r036.pre_ovf", 64'(ovf_cnt), 64'(8'd2));
    send(32'hAAAA_0001, 1'b0, 1'b0, 1'b0, acc);
    send(32'hBBBB_0002, 1'b0, 1'b0, 1'b0, acc);
    check("r036.full", 64'(in_ready), 64'(1'b0));
    apply_reset("r036.rst");
    dut_pop.delete();
    send(32'h5, 1'b0, 1'b0, 1'b0, acc);
    check("r036.valid", 64'(out_valid), 64'(1'b1));
    check("r036.sum",   64'(out_sum),   64'(32'h5));
    idle(1'b1);
    check("r036.alone", 64'(out_valid), 64'(1'b0));
    check("r036.n_out", 64'(dut_pop.size()), 64'(1));

    // Random traffic with corner-value sums and occasional clears.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom % 4)
        0:       s = 32'h0000_0000;
        1:       s = 32'h8000_0000;
        default: s = $urandom;
      endcase
      step(($urandom % 4) != 0, s, 1'($urandom % 2), 1'($urandom % 2),
           1'($urandom % 2), 1'($urandom % 2), ($urandom % 50) == 0, acc);
    end
    idle(1'b1);
    idle(1'b1);
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
